// File: rtl/h264quant_sched.sv
// rtl/h264quant_sched.sv - sequences one macroblock of 4x4/DC coefficient blocks into h264quantise
// Optional chroma QP mapping table (H.264 Table 8-15) enabled by defining CHROMA_QP_MAP_EN.
module h264quant_sched #(
  parameter int CREDITS = 2,
  parameter int GAP     = 1,
  parameter int DRAIN   = 3
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [5:0]  mbqp_i,
  input  logic [4:0]  cqpoff_i,
  input  logic        intra16_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        rd_en_o,
  output logic [8:0]  rd_addr_o,
  input  logic [15:0] rd_data_i,
  output logic        q_enable_o,
  output logic        q_dcci_o,
  output logic [5:0]  q_qp_o,
  output logic [15:0] q_ynin_o,
  output logic        blk_start_o,
  output logic [4:0]  blk_id_o,
  input  logic        credit_ret_i
);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_READ, S_GAP, S_DRAIN, S_FLUSH} state_t;

  state_t      state_q, state_d;
  logic [4:0]  blk_q, blk_d;
  logic [3:0]  coeff_q, coeff_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  credit_q, credit_d;
  logic [5:0]  qp_q, qp_d;
  logic [5:0]  qpc_q, qpc_d;
  logic        done_q, done_d;
  logic        q_enable_q, q_dcci_q, blk_start_q;
  logic [4:0]  blk_id_q;
  logic [15:0] q_ynin_q;

  logic              rd_en, launch, is_dc, last_coeff;
  logic [4:0]        next_blk;
  logic signed [6:0] qp_sum;
  logic [5:0]        qpi;

  function automatic logic [5:0] chroma_qp(input logic [5:0] q);
`ifdef CHROMA_QP_MAP_EN
    case (q)
      6'd30: return 6'd29;  6'd31: return 6'd30;  6'd32: return 6'd31;  6'd33: return 6'd32;
      6'd34: return 6'd32;  6'd35: return 6'd33;  6'd36: return 6'd34;  6'd37: return 6'd34;
      6'd38: return 6'd35;  6'd39: return 6'd35;  6'd40: return 6'd36;  6'd41: return 6'd36;
      6'd42: return 6'd37;  6'd43: return 6'd37;  6'd44: return 6'd37;  6'd45: return 6'd38;
      6'd46: return 6'd38;  6'd47: return 6'd38;  6'd48: return 6'd39;  6'd49: return 6'd39;
      6'd50: return 6'd39;  6'd51: return 6'd39;
      default: return q;
    endcase
`else
    return q;
`endif
  endfunction

  assign qp_sum = $signed({1'b0, mbqp_i}) + $signed({{2{cqpoff_i[4]}}, cqpoff_i});
  assign qpi    = (qp_sum < 7'sd0) ? 6'd0 : (qp_sum > 7'sd51) ? 6'd51 : qp_sum[5:0];

  assign rd_en      = (state_q == S_READ);
  assign launch     = (state_q == S_ARM) && (credit_q != 3'd0);
  assign is_dc      = (blk_q >= 5'd16) && (blk_q <= 5'd18);
  assign last_coeff = ((blk_q == 5'd17) || (blk_q == 5'd18)) ? (coeff_q == 4'd3) : (coeff_q == 4'd15);

  // Luma DC precedes luma 0..15; chroma DC 17,18 follows luma 15.
  always_comb begin
    next_blk = blk_q + 5'd1;
    if (blk_q == 5'd16) next_blk = 5'd0;
    else if (blk_q == 5'd15) next_blk = 5'd17;
  end

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    coeff_d = coeff_q;
    cnt_d   = cnt_q;
    qp_d    = qp_q;
    qpc_d   = qpc_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (start_i) begin
        state_d = S_ARM;
        blk_d   = intra16_i ? 5'd16 : 5'd0;
        qp_d    = mbqp_i;
        qpc_d   = chroma_qp(qpi);
      end
      S_ARM: if (launch) begin
        state_d = S_READ;
        coeff_d = 4'd0;
      end
      S_READ: begin
        coeff_d = coeff_q + 4'd1;
        if (last_coeff) begin
          coeff_d = 4'd0;
          blk_d   = next_blk;
          cnt_d   = 3'd0;
          if (blk_q == 5'd26) state_d = S_FLUSH;
          else if (blk_q == 5'd15) state_d = S_DRAIN;
          else state_d = S_GAP;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(GAP - 1)) state_d = S_ARM;
      end
      S_DRAIN: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(DRAIN - 1)) begin
          state_d = S_ARM;
          qp_d    = qpc_q;
        end
      end
      S_FLUSH: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd4) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A return coinciding with a launch cancels out; returns beyond CREDITS are dropped.
  always_comb begin
    credit_d = credit_q;
    if (launch && !credit_ret_i) credit_d = credit_q - 3'd1;
    else if (!launch && credit_ret_i && (credit_q != 3'(CREDITS))) credit_d = credit_q + 3'd1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      blk_q       <= 5'd0;
      coeff_q     <= 4'd0;
      cnt_q       <= 3'd0;
      credit_q    <= 3'(CREDITS);
      qp_q        <= 6'd0;
      qpc_q       <= 6'd0;
      done_q      <= 1'b0;
      q_enable_q  <= 1'b0;
      q_dcci_q    <= 1'b0;
      blk_start_q <= 1'b0;
      blk_id_q    <= 5'd0;
      q_ynin_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      coeff_q     <= coeff_d;
      cnt_q       <= cnt_d;
      credit_q    <= credit_d;
      qp_q        <= qp_d;
      qpc_q       <= qpc_d;
      done_q      <= done_d;
      q_enable_q  <= rd_en;
      q_dcci_q    <= rd_en && is_dc;
      blk_start_q <= rd_en && (coeff_q == 4'd0);
      if (rd_en && (coeff_q == 4'd0)) blk_id_q <= blk_q;
      q_ynin_q    <= rd_en ? rd_data_i : 16'd0;
    end
  end

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign rd_en_o     = rd_en;
  assign rd_addr_o   = rd_en ? {blk_q, coeff_q} : 9'd0;
  assign q_enable_o  = q_enable_q;
  assign q_dcci_o    = q_dcci_q;
  assign q_qp_o      = qp_q;
  assign q_ynin_o    = q_ynin_q;
  assign blk_start_o = blk_start_q;
  assign blk_id_o    = blk_id_q;

endmodule

// File: tb/tb_h264quant_sched.sv
// tb/tb_h264quant_sched.sv - directed self-checking bench for h264quant_sched
// Expected chroma QP follows CHROMA_QP_MAP_EN the same way the design does.
module tb_h264quant_sched;
  localparam int CREDITS = 2;
  localparam int GAP     = 1;
  localparam int DRAIN   = 3;

  logic        clk = 1'b0;
  logic        rst, start, intra16, credit_ret;
  logic [5:0]  mbqp;
  logic [4:0]  cqpoff;
  logic        busy, done, rd_en, q_enable, q_dcci, blk_start;
  logic [8:0]  rd_addr;
  logic [15:0] rd_data, q_ynin;
  logic [5:0]  q_qp;
  logic [4:0]  blk_id;

  always #5 clk = ~clk;

  // Coefficient buffer returns a word derived from its address, usable by the next edge.
  assign rd_data = rd_en ? {rd_addr, 7'h35} : 16'hDEAD;

  h264quant_sched #(.CREDITS(CREDITS), .GAP(GAP), .DRAIN(DRAIN)) dut (
    .clk_i(clk), .reset_i(rst), .start_i(start), .mbqp_i(mbqp), .cqpoff_i(cqpoff),
    .intra16_i(intra16), .busy_o(busy), .done_o(done), .rd_en_o(rd_en), .rd_addr_o(rd_addr),
    .rd_data_i(rd_data), .q_enable_o(q_enable), .q_dcci_o(q_dcci), .q_qp_o(q_qp),
    .q_ynin_o(q_ynin), .blk_start_o(blk_start), .blk_id_o(blk_id), .credit_ret_i(credit_ret)
  );

  int errors = 0;
  int checks = 0;
  int map_tbl[22] = '{29,30,31,32,32,33,34,34,35,35,36,36,37,37,37,38,38,38,39,39,39,39};

  logic [4:0] ids[$];
  logic [4:0] exp_order[$];
  logic [5:0] bqp[$];
  int lens[$];
  int dccnt[$];
  int done_cnt, ynin_err, qp_bad, idle_run, min_gap, done_gap, auto_credit;
  logic [5:0] prev_qp = 6'd0;
  logic prev_en = 1'b0;

  function automatic int exp_qpc(int qp, int off);
    int q;
    q = qp + off;
    if (q < 0) q = 0;
    if (q > 51) q = 51;
`ifdef CHROMA_QP_MAP_EN
    if (q >= 30) q = map_tbl[q - 30];
`endif
    return q;
  endfunction

  task automatic clear_log();
    ids.delete(); bqp.delete(); lens.delete(); dccnt.delete();
    done_cnt = 0; ynin_err = 0; qp_bad = 0; min_gap = 1000; done_gap = -1;
  endtask

  task automatic set_order(bit intra);
    exp_order.delete();
    if (intra) exp_order.push_back(5'd16);
    for (int i = 0; i < 16; i++) exp_order.push_back(5'(i));
    for (int i = 17; i < 27; i++) exp_order.push_back(5'(i));
  endtask

  task automatic tick();
    int k, c;
    logic [3:0] c4;
    logic [4:0] eid;
    logic [15:0] exp_y;
    @(negedge clk);
    if (q_enable) begin
      if (blk_start) begin
        if (ids.size() > 0 && idle_run < min_gap) min_gap = idle_run;
        ids.push_back(blk_id); lens.push_back(0); dccnt.push_back(0); bqp.push_back(q_qp);
      end
      if (lens.size() > 0) begin
        k = lens.size() - 1;
        c = lens[k];
        c4 = c[3:0];
        eid = (k < exp_order.size()) ? exp_order[k] : 5'h1f;
        exp_y = {eid, c4, 7'h35};
        if (q_ynin !== exp_y) ynin_err++;
        lens[k] = c + 1;
        if (q_dcci) dccnt[k] = dccnt[k] + 1;
      end
      idle_run = 0;
    end else idle_run++;
    if (q_qp !== prev_qp && (prev_en || q_enable || idle_run < DRAIN)) qp_bad++;
    if (done) begin done_cnt++; done_gap = idle_run; end
    prev_qp = q_qp;
    prev_en = q_enable;
    if (auto_credit != 0) credit_ret = blk_start;
  endtask

  task automatic run_mb(bit intra, int qp, int off, int restart_at);
    int n;
    clear_log();
    set_order(intra);
    mbqp = 6'(qp); cqpoff = 5'(off); intra16 = intra;
    start = 1'b1;
    tick();
    n = 1;
    while (done_cnt == 0 && n < 3000) begin
      if (n == restart_at) begin start = 1'b1; mbqp = 6'd10; cqpoff = 5'd0; intra16 = ~intra; end
      else start = 1'b0;
      tick();
      n++;
    end
    start = 1'b0;
    repeat (5) tick();
    checks++;
    if (done_cnt == 0) begin errors++; $display("FAIL done_timeout: no done within %0d cycles", n); end
  endtask

  task automatic check_mb(string name, int qp, int off);
    int bad_order, bad_len, bad_dc, bad_qp, el, eq;
    bad_order = 0; bad_len = 0; bad_dc = 0; bad_qp = 0;
    checks++;
    if (ids.size() !== exp_order.size()) begin
      errors++; $display("FAIL %s blocks: got %0d required %0d", name, ids.size(), exp_order.size());
    end
    for (int k = 0; k < ids.size() && k < exp_order.size(); k++) begin
      el = (exp_order[k] == 5'd17 || exp_order[k] == 5'd18) ? 4 : 16;
      eq = (exp_order[k] >= 5'd17) ? exp_qpc(qp, off) : qp;
      if (ids[k] !== exp_order[k]) bad_order++;
      if (lens[k] != el) bad_len++;
      if (dccnt[k] != ((exp_order[k] >= 5'd16 && exp_order[k] <= 5'd18) ? el : 0)) bad_dc++;
      if (bqp[k] !== 6'(eq)) bad_qp++;
    end
    checks++;
    if (bad_order != 0) begin errors++; $display("FAIL %s order: got %0d wrong ids required 0", name, bad_order); end
    checks++;
    if (bad_len != 0) begin errors++; $display("FAIL %s length: got %0d wrong lengths required 0", name, bad_len); end
    checks++;
    if (bad_dc != 0) begin errors++; $display("FAIL %s dcci: got %0d wrong blocks required 0", name, bad_dc); end
    checks++;
    if (bad_qp != 0) begin errors++; $display("FAIL %s qp: got %0d wrong blocks required 0", name, bad_qp); end
    checks++;
    if (ynin_err != 0) begin errors++; $display("FAIL %s ynin: got %0d bad words required 0", name, ynin_err); end
    checks++;
    if (qp_bad != 0) begin errors++; $display("FAIL %s qp_stable: got %0d early changes required 0", name, qp_bad); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL %s done_count: got %0d required 1", name, done_cnt); end
    checks++;
    if (done_gap != 5) begin errors++; $display("FAIL %s done_latency: got %0d required 5", name, done_gap); end
    checks++;
    if (min_gap < GAP) begin errors++; $display("FAIL %s gap: got %0d required >= %0d", name, min_gap, GAP); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_end: got %b required 0", name, busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mbqp = 6'd0; cqpoff = 5'd0; intra16 = 1'b0; credit_ret = 1'b0;
    auto_credit = 1; idle_run = 0;
    repeat (3) tick();
    checks++;
    if ({busy, done, rd_en, rd_addr, q_enable, q_dcci, q_qp, q_ynin, blk_start, blk_id} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h required 0",
        {busy, done, rd_en, rd_addr, q_enable, q_dcci, q_qp, q_ynin, blk_start, blk_id});
    end
    rst = 1'b0;
    repeat (2) tick();
    checks++;
    if ({busy, rd_en, q_enable} !== 3'b000) begin
      errors++; $display("FAIL idle_after_reset: got %b required 000", {busy, rd_en, q_enable});
    end
  endtask

  task automatic test_luma_order();
    run_mb(1'b0, 28, 0, 50);
    check_mb("luma_qp28", 28, 0);
  endtask

  task automatic test_intra16();
    run_mb(1'b1, 28, 0, -1);
    check_mb("intra16", 28, 0);
  endtask

  task automatic test_qp_map();
    run_mb(1'b0, 51, 12, -1);
    check_mb("qp51_off12", 51, 12);
    run_mb(1'b1, 35, -3, -1);
    check_mb("qp35_offm3", 35, -3);
  endtask

  task automatic test_qp_clamp();
    run_mb(1'b0, 2, -12, -1);
    check_mb("qp2_offm12", 2, -12);
  endtask

  task automatic test_credit_stall();
    auto_credit = 0;
    credit_ret = 1'b1;
    repeat (3) tick();
    credit_ret = 1'b0;
    clear_log();
    set_order(1'b0);
    mbqp = 6'd20; cqpoff = 5'd0; intra16 = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (300) tick();
    checks++;
    if (ids.size() != CREDITS) begin
      errors++; $display("FAIL stall_blocks: got %0d required %0d", ids.size(), CREDITS);
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b required 1", busy); end
    credit_ret = 1'b1;
    tick();
    credit_ret = 1'b0;
    repeat (100) tick();
    checks++;
    if (ids.size() != CREDITS + 1) begin
      errors++; $display("FAIL one_credit_blocks: got %0d required %0d", ids.size(), CREDITS + 1);
    end else begin
      checks++;
      if (ids[CREDITS] !== 5'(CREDITS)) begin
        errors++; $display("FAIL one_credit_id: got %0d required %0d", ids[CREDITS], CREDITS);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    auto_credit = 1;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    int n;
    clear_log();
    set_order(1'b0);
    mbqp = 6'd30; cqpoff = 5'd3; intra16 = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (ids.size() < 6 && n < 1000) begin tick(); n++; end
    checks++;
    if (ids.size() != 6 || rd_en !== 1'b1) begin
      errors++; $display("FAIL reach_block5: got %0d blocks rd_en=%b required 6 and 1", ids.size(), rd_en);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({busy, done, rd_en, rd_addr, q_enable, q_dcci, q_qp, q_ynin, blk_start, blk_id} !== '0) begin
      errors++; $display("FAIL midreset_outputs: got %h required 0",
        {busy, done, rd_en, rd_addr, q_enable, q_dcci, q_qp, q_ynin, blk_start, blk_id});
    end
    rst = 1'b0;
    repeat (20) tick();
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL midreset_done: got %0d required 0", done_cnt); end
    run_mb(1'b0, 28, 0, -1);
    check_mb("after_reset", 28, 0);
  endtask

  initial begin
    test_reset();
    test_luma_order();
    test_intra16();
    test_qp_map();
    test_qp_clamp();
    test_credit_stall();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
